seg_arb: RTL and testbench

SEG_ARB -- requirements
Module: seg_arb

---
 rtl/seg_arb.sv | 140 ++++++++++++++
 tb/tb_seg_arb.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_arb.sv
`default_nettype none
// ============================================================================
// Module   : seg_arb
// Brief    : Two-requester round-robin arbiter for a multi-digit display bus.
//            Define SEG_ARB_TIMEOUT_EN to enable forced release after MAX_OWN.
// Revision : 1.0 - initial release
// ============================================================================
module seg_arb #(
    parameter int unsigned SEG_NUM  = 8,
    parameter int unsigned HOLD_CYC = 1000,
    parameter int unsigned MAX_OWN  = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_a,
    input  logic [SEG_NUM*4-1:0] din_a,
    input  logic [SEG_NUM-1:0]   wr_a,
    output logic                 gnt_a,
    input  logic                 req_b,
    input  logic [SEG_NUM*4-1:0] din_b,
    input  logic [SEG_NUM-1:0]   wr_b,
    output logic                 gnt_b,
    output logic [SEG_NUM*4-1:0] din,
    output logic [SEG_NUM-1:0]   din_vld
);

`ifdef SEG_ARB_TIMEOUT_EN
    localparam bit c_TMO_EN = 1'b1;
`else
    localparam bit c_TMO_EN = 1'b0;
`endif

    // Counter only needs to reach the largest threshold it is compared against.
    localparam int unsigned c_CNT_LIM = c_TMO_EN ? MAX_OWN : HOLD_CYC;
    localparam int unsigned c_CNT_W   = $clog2(c_CNT_LIM + 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_END = c_CNT_W'(HOLD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_TMO_END  = c_CNT_W'(MAX_OWN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   last_q, last_d;     // 1'b1: B was the most recent owner
    logic [c_CNT_W-1:0]     own_cnt_q, own_cnt_d;
    logic [SEG_NUM*4-1:0]   din_q, din_d;
    logic [SEG_NUM-1:0]     vld_q, vld_d;
    logic                   gnt_a_q, gnt_b_q;

    logic [c_CNT_W-1:0]     w_cnt_inc;
    logic                   w_rel_a;
    logic                   w_rel_b;

    assign w_cnt_inc = (own_cnt_q == '1) ? own_cnt_q : own_cnt_q + c_CNT_W'(1);

    // Release: voluntary after the minimum hold, or forced when the other side waits too long.
    assign w_rel_a = (!req_a && (own_cnt_q >= c_HOLD_END)) ||
                     (c_TMO_EN && req_b && (own_cnt_q == c_TMO_END));
    assign w_rel_b = (!req_b && (own_cnt_q >= c_HOLD_END)) ||
                     (c_TMO_EN && req_a && (own_cnt_q == c_TMO_END));

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        own_cnt_d = own_cnt_q;
        din_d     = din_q;
        vld_d     = '0;
        case (state_q)
            IDLE: begin
                own_cnt_d = '0;
                if (req_a && (!req_b || last_q)) begin
                    state_d = OWN_A;
                    last_d  = 1'b0;
                end else if (req_b) begin
                    state_d = OWN_B;
                    last_d  = 1'b1;
                end
            end
            OWN_A: begin
                din_d = din_a;
                vld_d = wr_a;
                if (w_rel_a) begin
                    state_d   = IDLE;
                    own_cnt_d = '0;
                end else begin
                    own_cnt_d = w_cnt_inc;
                end
            end
            OWN_B: begin
                din_d = din_b;
                vld_d = wr_b;
                if (w_rel_b) begin
                    state_d   = IDLE;
                    own_cnt_d = '0;
                end else begin
                    own_cnt_d = w_cnt_inc;
                end
            end
            default: begin
                state_d   = IDLE;
                own_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            own_cnt_q <= '0;
            din_q     <= '0;
            vld_q     <= '0;
            gnt_a_q   <= 1'b0;
            gnt_b_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            own_cnt_q <= own_cnt_d;
            din_q     <= din_d;
            vld_q     <= vld_d;
            gnt_a_q   <= (state_d == OWN_A);
            gnt_b_q   <= (state_d == OWN_B);
        end
    end

    assign gnt_a   = gnt_a_q;
    assign gnt_b   = gnt_b_q;
    assign din     = din_q;
    assign din_vld = vld_q;

`ifndef SYNTHESIS
    a_gnt_exclusive : assert property (@(posedge clk) !(gnt_a_q && gnt_b_q));
    a_idle_between  : assert property (@(posedge clk) disable iff (!rst_n)
                                       (gnt_a_q |=> !gnt_b_q) and (gnt_b_q |=> !gnt_a_q));
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg_arb.sv
`default_nettype none
// Testbench for seg_arb: directed scenarios plus randomized traffic against a
// cycle-level ownership model. Build with SEG_ARB_TIMEOUT_EN to cover forced release.
module tb_seg_arb;
    localparam int SEG_NUM  = 8;
    localparam int HOLD_CYC = 4;
    localparam int MAX_OWN  = 16;
`ifdef SEG_ARB_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_a = 1'b0, req_b = 1'b0;
    logic [31:0] din_a = '0,   din_b = '0;
    logic [7:0]  wr_a  = '0,   wr_b  = '0;
    logic        gnt_a, gnt_b;
    logic [31:0] din;
    logic [7:0]  din_vld;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner 0 = none, 1 = A, 2 = B
    int          m_owner = 0;
    int          m_cycles = 0;
    int          m_last = 2;
    logic [31:0] m_din = '0;
    logic [7:0]  m_vld = '0;

    seg_arb #(
        .SEG_NUM  (SEG_NUM),
        .HOLD_CYC (HOLD_CYC),
        .MAX_OWN  (MAX_OWN)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_a   (req_a),
        .din_a   (din_a),
        .wr_a    (wr_a),
        .gnt_a   (gnt_a),
        .req_b   (req_b),
        .din_b   (din_b),
        .wr_b    (wr_b),
        .gnt_b   (gnt_b),
        .din     (din),
        .din_vld (din_vld)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (checks %0d errors %0d)", n_checks, n_errors);
        $fatal(1);
    end

    // Apply the arbitration rules to the inputs seen at this edge.
    task automatic model_step();
        bit mine, other, release_now;
        if (!rst_n) begin
            m_owner = 0; m_cycles = 0; m_last = 2; m_din = '0; m_vld = '0;
            return;
        end
        if (m_owner == 0) begin
            m_vld = '0;
            if (req_a && req_b) m_owner = (m_last == 1) ? 2 : 1;
            else if (req_a)     m_owner = 1;
            else if (req_b)     m_owner = 2;
            if (m_owner != 0) begin
                m_last   = m_owner;
                m_cycles = 0;
            end
        end else begin
            m_din = (m_owner == 1) ? din_a : din_b;
            m_vld = (m_owner == 1) ? wr_a  : wr_b;
            mine  = (m_owner == 1) ? req_a : req_b;
            other = (m_owner == 1) ? req_b : req_a;
            // this is ownership cycle number m_cycles+1
            release_now = (!mine && (m_cycles + 1 >= HOLD_CYC)) ||
                          (TMO && other && (m_cycles + 1 == MAX_OWN));
            if (release_now) m_owner = 0;
            else             m_cycles++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1; wr_a = '1; wr_b = '1;
        din_a = $urandom; din_b = $urandom;
        cycle(); cycle();
        n_checks++; if (gnt_a !== 1'b0) begin n_errors++; $display("FAIL reset_gnt_a: got %b want 0", gnt_a); end
        n_checks++; if (gnt_b !== 1'b0) begin n_errors++; $display("FAIL reset_gnt_b: got %b want 0", gnt_b); end
        n_checks++; if (din !== 32'h0) begin n_errors++; $display("FAIL reset_din: got %h want 0", din); end
        n_checks++; if (din_vld !== 8'h0) begin n_errors++; $display("FAIL reset_vld: got %h want 0", din_vld); end
    endtask

    task automatic test_round_robin();
        int n;
        rst_n = 1'b1; wr_a = '0; wr_b = '0; req_a = 1'b1; req_b = 1'b1;
        cycle();
        n_checks++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin
            n_errors++; $display("FAIL rr_first_tie: got a=%b b=%b want a=1 b=0", gnt_a, gnt_b); end
        req_a = 1'b0;
        n = 1;
        for (int k = 0; k < 20 && gnt_a === 1'b1; k++) begin
            cycle();
            if (gnt_a === 1'b1) n++;
        end
        n_checks++; if (n != HOLD_CYC) begin n_errors++; $display("FAIL rr_a_hold: got %0d cycles want %0d", n, HOLD_CYC); end
        n_checks++; if (gnt_b !== 1'b0) begin n_errors++; $display("FAIL rr_idle_gap: got gnt_b=%b want 0", gnt_b); end
        cycle();
        n_checks++; if (gnt_b !== 1'b1) begin n_errors++; $display("FAIL rr_then_b: got gnt_b=%b want 1", gnt_b); end
        req_b = 1'b0;
        for (int k = 0; k < 20 && gnt_b === 1'b1; k++) cycle();
        n_checks++; if (gnt_b !== 1'b0) begin n_errors++; $display("FAIL rr_b_release: got gnt_b=%b want 0", gnt_b); end
    endtask

    task automatic test_write_forward();
        logic [31:0] held;
        held = m_din;
        req_a = 1'b1; wr_a = 8'hFF; din_a = 32'hDEAD_BEEF;
        cycle();
        n_checks++; if (gnt_a !== 1'b1) begin n_errors++; $display("FAIL wf_grant: got gnt_a=%b want 1", gnt_a); end
        n_checks++; if (din_vld !== 8'h00) begin n_errors++; $display("FAIL wf_entry_vld: got %h want 00", din_vld); end
        n_checks++; if (din !== held) begin n_errors++; $display("FAIL wf_entry_din: got %h want %h", din, held); end
        wr_a = 8'h01; din_a = 32'h0000_0005; wr_b = 8'hFF; din_b = 32'hFFFF_FFFF;
        cycle();
        n_checks++; if (din_vld !== 8'h01) begin n_errors++; $display("FAIL wf_vld: got %h want 01", din_vld); end
        n_checks++; if (din !== 32'h0000_0005) begin n_errors++; $display("FAIL wf_din: got %h want 00000005", din); end
        wr_a = 8'h00;
        cycle();
        n_checks++; if (din_vld !== 8'h00) begin n_errors++; $display("FAIL wf_nonowner: got %h want 00", din_vld); end
        wr_b = 8'h00; req_a = 1'b0;
        for (int k = 0; k < 20 && gnt_a === 1'b1; k++) cycle();
    endtask

    task automatic test_hold();
        req_a = 1'b1; req_b = 1'b0;
        cycle();
        req_a = 1'b0;
        n_checks++; if (gnt_a !== 1'b1) begin n_errors++; $display("FAIL hold_grant: got gnt_a=%b want 1", gnt_a); end
        for (int k = 1; k < HOLD_CYC; k++) begin
            cycle();
            n_checks++; if (gnt_a !== 1'b1) begin n_errors++; $display("FAIL hold_cycle%0d: got gnt_a=%b want 1", k + 1, gnt_a); end
        end
        wr_a = 8'h80; din_a = 32'h9000_0000;
        cycle();
        n_checks++; if (gnt_a !== 1'b0 || gnt_b !== 1'b0) begin
            n_errors++; $display("FAIL hold_idle: got a=%b b=%b want 0 0", gnt_a, gnt_b); end
        n_checks++; if (din_vld !== 8'h80 || din !== 32'h9000_0000) begin
            n_errors++; $display("FAIL hold_last_write: got vld=%h din=%h want 80 90000000", din_vld, din); end
        wr_a = 8'h00; din_a = 32'h1234_5678;
        cycle();
        n_checks++; if (din_vld !== 8'h00 || din !== 32'h9000_0000) begin
            n_errors++; $display("FAIL hold_idle_data: got vld=%h din=%h want 00 90000000", din_vld, din); end
    endtask

    task automatic test_timeout();
        int n;
        req_a = 1'b1; req_b = 1'b0;
        cycle();
        n_checks++; if (gnt_a !== 1'b1) begin n_errors++; $display("FAIL to_grant: got gnt_a=%b want 1", gnt_a); end
        req_b = 1'b1;
        n = 1;
        for (int k = 0; k < 40 && gnt_a === 1'b1; k++) begin
            cycle();
            if (gnt_a === 1'b1) n++;
        end
`ifdef SEG_ARB_TIMEOUT_EN
        n_checks++; if (n != MAX_OWN) begin n_errors++; $display("FAIL to_len: got %0d cycles want %0d", n, MAX_OWN); end
        n_checks++; if (gnt_b !== 1'b0) begin n_errors++; $display("FAIL to_idle: got gnt_b=%b want 0", gnt_b); end
        cycle();
        n_checks++; if (gnt_b !== 1'b1) begin n_errors++; $display("FAIL to_b_wins: got gnt_b=%b want 1", gnt_b); end
`else
        n_checks++; if (gnt_a !== 1'b1) begin n_errors++; $display("FAIL to_no_release: got gnt_a=%b want 1 (held %0d)", gnt_a, n); end
        n_checks++; if (gnt_b !== 1'b0) begin n_errors++; $display("FAIL to_b_waits: got gnt_b=%b want 0", gnt_b); end
`endif
        req_a = 1'b0; req_b = 1'b0;
        for (int k = 0; k < 20 && (gnt_a === 1'b1 || gnt_b === 1'b1); k++) cycle();
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        req_b = 1'b1; req_a = 1'b0;
        for (int k = 0; k < 10 && gnt_b !== 1'b1; k++) cycle();
        n_checks++; if (gnt_b !== 1'b1) begin n_errors++; $display("FAIL rm_grant_b: got gnt_b=%b want 1", gnt_b); end
        wr_b = 8'hFF; din_b = $urandom; v = din_b;
        cycle();
        n_checks++; if (din_vld !== 8'hFF || din !== v) begin
            n_errors++; $display("FAIL rm_write: got vld=%h din=%h want ff %h", din_vld, din, v); end
        rst_n = 1'b0;
        cycle();
        n_checks++; if (gnt_b !== 1'b0 || gnt_a !== 1'b0) begin
            n_errors++; $display("FAIL rm_gnt: got a=%b b=%b want 0 0", gnt_a, gnt_b); end
        n_checks++; if (din !== 32'h0 || din_vld !== 8'h0) begin
            n_errors++; $display("FAIL rm_data: got din=%h vld=%h want 0 0", din, din_vld); end
        rst_n = 1'b1; req_b = 1'b0;
        cycle();
        n_checks++; if (din_vld !== 8'h0 || gnt_b !== 1'b0) begin
            n_errors++; $display("FAIL rm_after: got vld=%h gnt_b=%b want 00 0", din_vld, gnt_b); end
        wr_b = 8'h00;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) req_a = ~req_a;
            if ($urandom_range(7) == 0) req_b = ~req_b;
            wr_a  = $urandom; wr_b = $urandom;
            din_a = $urandom; din_b = $urandom;
            rst_n = ($urandom_range(199) != 0);
            cycle();
            n_checks++; if (gnt_a !== (m_owner == 1)) begin
                n_errors++; $display("FAIL rnd_gnt_a @%0d: got %b want %b", i, gnt_a, m_owner == 1); end
            n_checks++; if (gnt_b !== (m_owner == 2)) begin
                n_errors++; $display("FAIL rnd_gnt_b @%0d: got %b want %b", i, gnt_b, m_owner == 2); end
            n_checks++; if (din !== m_din) begin
                n_errors++; $display("FAIL rnd_din @%0d: got %h want %h", i, din, m_din); end
            n_checks++; if (din_vld !== m_vld) begin
                n_errors++; $display("FAIL rnd_vld @%0d: got %h want %h", i, din_vld, m_vld); end
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_write_forward();
        test_hold();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
